// File: rtl/satarx_10b8b.sv
// 10b/8b receive decoder with running-disparity tracking and a one-deep
// registered output stage (valid/ready on both sides).
module satarx_10b8b #(
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       S_VALID,
    output logic       S_READY,
    input  logic [9:0] S_DATA,
    output logic       M_VALID,
    input  logic       M_READY,
    output logic [8:0] M_DATA,
    output logic       o_code_err,
    output logic       o_disp_err,
    output logic       o_comma
);

    typedef enum logic [1:0] {RD_UNK, RD_NEG, RD_POS} rd_e;

    rd_e        rd_q, rd_d, rd_mid, rd_end;
    logic       m_valid_q;
    logic [8:0] m_data_q, m_data_d;
    logic       code_err_q, code_err_d;
    logic       disp_err_q, disp_err_d;
    logic       comma_q, comma_d;

    logic [5:0] s6;
    logic [3:0] s4, f4;
    logic [4:0] x5;
    logic [2:0] y3;
    logic [2:0] ones6, ones4;
    logic       ok6, ok4, k28, a7, p7;
    logic       is_k, pair_err, err6, err4;
    logic       x_kx7, x_a7n, x_a7p;
    logic       accept;

    assign s6      = S_DATA[9:4];
    assign s4      = S_DATA[3:0];
    assign ones6   = 3'($countones(s6));
    assign ones4   = 3'($countones(s4));
    assign S_READY = !m_valid_q || M_READY;
    assign accept  = S_VALID && S_READY;

    // 6b -> 5b; both disparity forms map to the same x.
    always_comb begin
        ok6 = 1'b1;
        k28 = 1'b0;
        x5  = '0;
        case (s6)
            6'b100111, 6'b011000: x5 = 5'd0;
            6'b011101, 6'b100010: x5 = 5'd1;
            6'b101101, 6'b010010: x5 = 5'd2;
            6'b110001:            x5 = 5'd3;
            6'b110101, 6'b001010: x5 = 5'd4;
            6'b101001:            x5 = 5'd5;
            6'b011001:            x5 = 5'd6;
            6'b111000, 6'b000111: x5 = 5'd7;
            6'b111001, 6'b000110: x5 = 5'd8;
            6'b100101:            x5 = 5'd9;
            6'b010101:            x5 = 5'd10;
            6'b110100:            x5 = 5'd11;
            6'b001101:            x5 = 5'd12;
            6'b101100:            x5 = 5'd13;
            6'b011100:            x5 = 5'd14;
            6'b010111, 6'b101000: x5 = 5'd15;
            6'b011011, 6'b100100: x5 = 5'd16;
            6'b100011:            x5 = 5'd17;
            6'b010011:            x5 = 5'd18;
            6'b110010:            x5 = 5'd19;
            6'b001011:            x5 = 5'd20;
            6'b101010:            x5 = 5'd21;
            6'b011010:            x5 = 5'd22;
            6'b111010, 6'b000101: x5 = 5'd23;
            6'b110011, 6'b001100: x5 = 5'd24;
            6'b100110:            x5 = 5'd25;
            6'b010110:            x5 = 5'd26;
            6'b110110, 6'b001001: x5 = 5'd27;
            6'b001110:            x5 = 5'd28;
            6'b101110, 6'b010001: x5 = 5'd29;
            6'b011110, 6'b100001: x5 = 5'd30;
            6'b101011, 6'b010100: x5 = 5'd31;
            6'b001111, 6'b110000: begin x5 = 5'd28; k28 = 1'b1; end
            default:              ok6 = 1'b0;
        endcase
    end

    // K28 after 110000 uses the complement of its 001111 4b form, so fold it back first.
    always_comb begin
        f4  = (k28 && s6[5]) ? ~s4 : s4;
        ok4 = 1'b1;
        a7  = 1'b0;
        p7  = 1'b0;
        y3  = '0;
        case (f4)
            4'b1011, 4'b0100: y3 = 3'd0;
            4'b1001:          y3 = 3'd1;
            4'b0101:          y3 = 3'd2;
            4'b1100, 4'b0011: y3 = 3'd3;
            4'b1101, 4'b0010: y3 = 3'd4;
            4'b1010:          y3 = 3'd5;
            4'b0110:          y3 = 3'd6;
            4'b1110, 4'b0001: begin y3 = 3'd7; p7 = 1'b1; end
            4'b0111, 4'b1000: begin y3 = 3'd7; a7 = 1'b1; end
            default:          ok4 = 1'b0;
        endcase
    end

    always_comb begin
        x_kx7    = (x5 == 5'd23) || (x5 == 5'd27) || (x5 == 5'd29) || (x5 == 5'd30);
        x_a7n    = (x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20);
        x_a7p    = (x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14);
        is_k     = 1'b0;
        pair_err = 1'b0;
        if (k28) begin
            is_k     = 1'b1;
            pair_err = p7;
        end else if (a7) begin
            if (x_kx7)
                is_k = 1'b1;
            else if (!((s4 == 4'b0111 && x_a7n) || (s4 == 4'b1000 && x_a7p)))
                pair_err = 1'b1;
        end else if (p7) begin
            // Where the alternate form is mandatory, the primary form never appears.
            pair_err = (s4 == 4'b1110 && x_a7n) || (s4 == 4'b0001 && x_a7p);
        end
    end

    always_comb begin
        err6   = 1'b0;
        rd_mid = rd_q;
        if (ones6 == 3'd4) begin
            err6   = (rd_q == RD_POS);
            rd_mid = RD_POS;
        end else if (ones6 == 3'd2) begin
            err6   = (rd_q == RD_NEG);
            rd_mid = RD_NEG;
        end else if (s6 == 6'b000111) begin
            rd_mid = RD_POS;
        end else if (s6 == 6'b111000) begin
            rd_mid = RD_NEG;
        end

        err4   = 1'b0;
        rd_end = rd_mid;
        if (ones4 == 3'd3) begin
            err4   = (rd_mid == RD_POS);
            rd_end = RD_POS;
        end else if (ones4 == 3'd1) begin
            err4   = (rd_mid == RD_NEG);
            rd_end = RD_NEG;
        end else if (s4 == 4'b0011) begin
            rd_end = RD_POS;
        end else if (s4 == 4'b1100) begin
            rd_end = RD_NEG;
        end

        code_err_d = !ok6 || !ok4 || pair_err;
        if (code_err_d) begin
            m_data_d   = 9'h1ff;
            disp_err_d = 1'b0;
            comma_d    = 1'b0;
            rd_d       = RD_UNK;
        end else begin
            m_data_d   = {is_k, y3, x5};
            disp_err_d = err6 || err4;
            comma_d    = k28 && ((y3 == 3'd1) || (y3 == 3'd5) || (y3 == 3'd7));
            rd_d       = rd_end;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            code_err_q <= 1'b0;
            disp_err_q <= 1'b0;
            comma_q    <= 1'b0;
            rd_q       <= RD_UNK;
        end else if (accept) begin
            m_valid_q  <= 1'b1;
            m_data_q   <= m_data_d;
            code_err_q <= code_err_d;
            disp_err_q <= disp_err_d;
            comma_q    <= comma_d;
            rd_q       <= rd_d;
        end else if (M_READY) begin
            m_valid_q <= 1'b0;
            if (OPT_LOWPOWER) begin
                m_data_q   <= '0;
                code_err_q <= 1'b0;
                disp_err_q <= 1'b0;
                comma_q    <= 1'b0;
            end
        end
    end

    assign M_VALID    = m_valid_q;
    assign M_DATA     = m_data_q;
    assign o_code_err = code_err_q;
    assign o_disp_err = disp_err_q;
    assign o_comma    = comma_q;

endmodule

// File: tb/tb_satarx_10b8b.sv
// Bench for satarx_10b8b: directed vector table, stall/reset sequences and
// random 8b10b traffic scored against an encoder-derived reference model.
module tb_satarx_10b8b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       S_VALID, S_READY, M_VALID, M_READY;
    logic [9:0] S_DATA;
    logic [8:0] M_DATA;
    logic       o_code_err, o_disp_err, o_comma;

    always #5 clk = ~clk;

    satarx_10b8b #(.OPT_LOWPOWER(1'b0)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .S_DATA     (S_DATA),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA),
        .o_code_err (o_code_err),
        .o_disp_err (o_disp_err),
        .o_comma    (o_comma)
    );

    typedef struct packed {
        logic [8:0] data;
        logic       ce;
        logic       de;
        logic       cm;
    } res_t;

    typedef struct packed {
        logic [9:0] sym;
        res_t       exp;
    } vec_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    res_t exp_q[$];
    bit   lut_ok[1024];
    logic [8:0] lut_val[1024];
    int   rd_m;     // -1 negative, +1 positive, 0 unknown
    bit   enc_rd;   // transmitter-side disparity: 0 = RD-, 1 = RD+

    // Standard 5b/6b and 3b/4b code tables, RD- column.
    logic [5:0] six_n[32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [3:0] four_n[8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] kfour_p[8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    logic [4:0] kx7[4] = '{5'd23, 5'd27, 5'd29, 5'd30};
    logic [9:0] bad[5] = '{10'h3FF, 10'h000, 10'h0FF, 10'h3C0, 10'h23E};

    function automatic logic [10:0] encode(input bit k, input logic [7:0] b, input bit rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        bit         r;
        x  = b[4:0];
        y  = b[7:5];
        r  = rd;
        c6 = (k && x == 5'd28) ? 6'b001111 : six_n[x];
        if (r && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
        if ($countones(c6) != 3) r = !r;
        if (k && x == 5'd28)
            c4 = r ? kfour_p[y] : ~kfour_p[y];
        else if (y == 3'd7 && (k || (!r && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                                 || (r && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
            c4 = r ? 4'b1000 : 4'b0111;
        else begin
            c4 = four_n[y];
            if (r && ($countones(c4) != 2 || c4 == 4'b1100)) c4 = ~c4;
        end
        if ($countones(c4) != 2) r = !r;
        return {r, c6, c4};
    endfunction

    function automatic int sub_rd(input int rd, input int d, input bit setp, input bit setn,
                                  output bit err);
        err = 1'b0;
        if (d > 0) begin err = (rd > 0); return 1; end
        if (d < 0) begin err = (rd < 0); return -1; end
        if (setp) return 1;
        if (setn) return -1;
        return rd;
    endfunction

    function automatic res_t model(input logic [9:0] s);
        res_t r;
        bit   e1, e2;
        int   d6, d4;
        if (!lut_ok[s]) begin
            rd_m = 0;
            r    = '{9'h1ff, 1'b1, 1'b0, 1'b0};
            return r;
        end
        d6   = 2 * $countones(s[9:4]) - 6;
        d4   = 2 * $countones(s[3:0]) - 4;
        rd_m = sub_rd(rd_m, d6, s[9:4] == 6'b000111, s[9:4] == 6'b111000, e1);
        rd_m = sub_rd(rd_m, d4, s[3:0] == 4'b0011, s[3:0] == 4'b1100, e2);
        r.data = lut_val[s];
        r.ce   = 1'b0;
        r.de   = e1 | e2;
        r.cm   = (r.data == 9'h13C) || (r.data == 9'h1BC) || (r.data == 9'h1FC);
        return r;
    endfunction

    function automatic logic [9:0] gen_sym();
        int          r;
        bit          k;
        logic [7:0]  b;
        logic [10:0] e;
        r = int'($urandom_range(0, 39));
        if (r == 0) return bad[$urandom_range(0, 4)];
        k = ($urandom_range(0, 7) == 0);
        if (k) begin
            if ($urandom_range(0, 1) == 1) b = {3'($urandom_range(0, 7)), 5'd28};
            else                           b = {3'd7, kx7[$urandom_range(0, 3)]};
        end else begin
            b = 8'($urandom_range(0, 255));
        end
        e      = encode(k, b, (r <= 3) ? !enc_rd : enc_rd);
        enc_rd = e[10];
        return e[9:0];
    endfunction

    function automatic vec_t mkv(input logic [9:0] s, input logic [8:0] d,
                                 input logic ce, input logic de, input logic cm);
        vec_t v;
        v.sym = s;
        v.exp = '{d, ce, de, cm};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit sv, input logic [9:0] sd, input bit mr,
                        input bit use_e, input res_t e, output bit acc);
        res_t x;
        bit   exp_mv, exp_sr;
        @(negedge clk);
        S_VALID = sv;
        S_DATA  = sd;
        M_READY = mr;
        #1;
        exp_mv = (exp_q.size() != 0);
        exp_sr = !exp_mv || mr;
        chk("m_valid", M_VALID, exp_mv);
        chk("s_ready", S_READY, exp_sr);
        if (exp_mv && mr) begin
            x = exp_q.pop_front();
            chk("m_data", M_DATA, x.data);
            chk("code_err", o_code_err, x.ce);
            chk("disp_err", o_disp_err, x.de);
            chk("comma", o_comma, x.cm);
        end
        acc = sv && exp_sr;
        if (acc) begin
            x = model(sd);
            exp_q.push_back(use_e ? e : x);
        end
    endtask

    task automatic drain(input string nm);
        bit acc;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, '0, acc);
        chk(nm, exp_q.size(), 0);
    endtask

    // Reset is applied between clock edges so the output must drop without a clock.
    task automatic do_reset(input string nm);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        S_VALID = 1'b0;
        M_READY = 1'b0;
        #1;
        chk({nm, "_mvalid"}, M_VALID, 0);
        chk({nm, "_mdata"}, M_DATA, 0);
        chk({nm, "_flags"}, {o_code_err, o_disp_err, o_comma}, 0);
        chk({nm, "_sready"}, S_READY, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        rd_m   = 0;
        enc_rd = 1'b0;
    endtask

    initial begin
        vec_t       tab[16];
        bit         acc;
        logic [9:0] cur;
        logic [10:0] e;

        for (int i = 0; i < 1024; i++) begin
            lut_ok[i]  = 1'b0;
            lut_val[i] = '0;
        end
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 256; b++) begin
                logic [7:0] bb;
                bb = b[7:0];
                if (k == 1 && !(bb[4:0] == 5'd28 || (bb[7:5] == 3'd7 &&
                    (bb[4:0] == 5'd23 || bb[4:0] == 5'd27 || bb[4:0] == 5'd29 || bb[4:0] == 5'd30))))
                    continue;
                for (int rd = 0; rd < 2; rd++) begin
                    e = encode(k == 1, bb, rd == 1);
                    lut_ok[e[9:0]]  = 1'b1;
                    lut_val[e[9:0]] = {k[0], bb};
                end
            end

        tab[0]  = mkv(10'h0FA, 9'h1BC, 0, 0, 1);
        tab[1]  = mkv(10'h18B, 9'h000, 0, 0, 0);
        tab[2]  = mkv(10'h2AA, 9'h0B5, 0, 0, 0);
        tab[3]  = mkv(10'h274, 9'h000, 0, 1, 0);
        tab[4]  = mkv(10'h0FA, 9'h1BC, 0, 0, 1);
        tab[5]  = mkv(10'h3FF, 9'h1FF, 1, 0, 0);
        tab[6]  = mkv(10'h305, 9'h1BC, 0, 0, 1);
        tab[7]  = mkv(10'h305, 9'h1BC, 0, 1, 1);
        tab[8]  = mkv(10'h0F8, 9'h1FC, 0, 0, 1);
        tab[9]  = mkv(10'h057, 9'h1F7, 0, 1, 0);
        tab[10] = mkv(10'h237, 9'h0F1, 0, 1, 0);
        tab[11] = mkv(10'h23E, 9'h1FF, 1, 0, 0);
        tab[12] = mkv(10'h073, 9'h067, 0, 0, 0);
        tab[13] = mkv(10'h18B, 9'h000, 0, 0, 0);
        tab[14] = mkv(10'h0FF, 9'h1FF, 1, 0, 0);
        tab[15] = mkv(10'h000, 9'h1FF, 1, 0, 0);

        S_VALID = 1'b0;
        S_DATA  = '0;
        M_READY = 1'b0;
        rd_m    = 0;
        enc_rd  = 1'b0;
        do_reset("reset");

        for (int i = 0; i < 16; i++) step(1'b1, tab[i].sym, 1'b1, 1'b1, tab[i].exp, acc);
        drain("table_drain");

        // Output stall: first word must stay put and nothing else gets in.
        step(1'b1, 10'h0FA, 1'b0, 1'b0, '0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10'h18B, 1'b0, 1'b0, '0, acc);
            chk("stall_data", M_DATA, 9'h1BC);
            chk("stall_comma", o_comma, 1);
        end
        step(1'b1, 10'h18B, 1'b1, 1'b0, '0, acc);
        step(1'b1, 10'h2AA, 1'b1, 1'b0, '0, acc);
        step(1'b1, 10'h0FA, 1'b1, 1'b0, '0, acc);
        drain("stall_drain");

        // Reset with a word pending, after RD has gone positive.
        step(1'b1, 10'h0FA, 1'b0, 1'b0, '0, acc);
        step(1'b0, '0, 1'b0, 1'b0, '0, acc);
        do_reset("midrst");
        step(1'b1, 10'h274, 1'b1, 1'b1, '{9'h000, 1'b0, 1'b0, 1'b0}, acc);
        drain("midrst_drain");

        do_reset("rnd_reset");
        cur = gen_sym();
        for (int i = 0; i < 4000; i++) begin
            bit sv, mr;
            sv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            step(sv, cur, mr, 1'b0, '0, acc);
            if (acc) cur = gen_sym();
        end
        drain("rnd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
